// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: scans OAM for the next line and writes Y-hit
// sprites into the view RAM. Optional SPRITE_EVAL_CLEAR_EN fills unused slots.
module sprite_line_eval #(
   parameter int OAM_NUM  = 64,
   parameter int VIEW_NUM = 8,
   parameter int TILE_H   = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          lineStart,
   input  logic [7:0]                    lineY,
   output logic [$clog2(OAM_NUM)-1:0]    oamAddr,
   input  logic [31:0]                   oamData,
   output logic                          viewWe,
   output logic [$clog2(VIEW_NUM)-1:0]   viewAddr,
   output logic [31:0]                   viewData,
   output logic [$clog2(VIEW_NUM):0]     viewCount,
   output logic                          overflow,
   output logic                          busy,
   output logic                          done
);

   localparam int OW = $clog2(OAM_NUM);
   localparam int VW = $clog2(VIEW_NUM);
   localparam int CW = VW + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      DRAIN = 3'd2,
`ifdef SPRITE_EVAL_CLEAR_EN
      CLEAR = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

   state_t state, nextState;

   logic [7:0]    curY;
   logic [CW-1:0] hitCnt;
   logic          ovfFlag;
   logic          dataValid;
   logic          drainCnt;
   logic          isHit;
   logic [8:0]    y9, p9;

   // 9-bit compare so posY near 0xFF never wraps onto low lines
   assign y9    = {1'b0, curY};
   assign p9    = {1'b0, oamData[23:16]};
   assign isHit = (y9 >= p9) && (y9 < p9 + 9'(TILE_H));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

`ifdef SPRITE_EVAL_CLEAR_EN
   logic [CW-1:0] clrPtr;
   logic [CW-1:0] clrSlot;
   assign clrSlot = (state == CLEAR) ? clrPtr : hitCnt;
`endif

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (lineStart) nextState = SCAN;
         SCAN:  if (oamAddr == OW'(OAM_NUM - 1)) nextState = DRAIN;
         DRAIN: begin
            if (drainCnt) begin
`ifdef SPRITE_EVAL_CLEAR_EN
               nextState = (hitCnt < CW'(VIEW_NUM)) ? CLEAR : DONE;
`else
               nextState = DONE;
`endif
            end
         end
`ifdef SPRITE_EVAL_CLEAR_EN
         CLEAR: if (clrPtr == CW'(VIEW_NUM)) nextState = DONE;
`endif
         DONE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         oamAddr   <= '0;
         viewWe    <= 1'b0;
         viewAddr  <= '0;
         viewData  <= '0;
         viewCount <= '0;
         overflow  <= 1'b0;
         curY      <= '0;
         hitCnt    <= '0;
         ovfFlag   <= 1'b0;
         dataValid <= 1'b0;
         drainCnt  <= 1'b0;
`ifdef SPRITE_EVAL_CLEAR_EN
         clrPtr    <= '0;
`endif
      end else begin
         state     <= nextState;
         viewWe    <= 1'b0;
         // OAM data for an address issued in SCAN arrives one cycle later
         dataValid <= (state == SCAN);

         if (state == IDLE && lineStart) begin
            curY    <= lineY;
            hitCnt  <= '0;
            ovfFlag <= 1'b0;
            oamAddr <= '0;
         end else if (state == SCAN && nextState == SCAN) begin
            oamAddr <= oamAddr + 1'b1;
         end

         drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;

         if (dataValid && isHit) begin
            if (hitCnt < CW'(VIEW_NUM)) begin
               viewWe   <= 1'b1;
               viewAddr <= hitCnt[VW-1:0];
               viewData <= oamData;
               hitCnt   <= hitCnt + 1'b1;
            end else begin
               ovfFlag <= 1'b1;
            end
         end

`ifdef SPRITE_EVAL_CLEAR_EN
         // Off-screen filler so drawers can ignore slots without checking viewCount
         if (nextState == CLEAR) begin
            viewWe   <= 1'b1;
            viewAddr <= clrSlot[VW-1:0];
            viewData <= 32'hFFFF_0000;
            clrPtr   <= clrSlot + 1'b1;
         end
`endif

         if (nextState == DONE) begin
            viewCount <= hitCnt;
            overflow  <= ovfFlag;
         end
      end
   end

endmodule

// File: tb/tb_sprite_line_eval.sv
// Directed bench for sprite_line_eval: OAM model, write scoreboard, timing checks.
// Follows SPRITE_EVAL_CLEAR_EN to expect clear writes when the macro is set.
module tb_sprite_line_eval;

   logic        clk = 1'b0;
   logic        rstn;
   logic        lineStart;
   logic [7:0]  lineY;
   logic [5:0]  oamAddr;
   logic [31:0] oamData;
   logic        viewWe;
   logic [2:0]  viewAddr;
   logic [31:0] viewData;
   logic [3:0]  viewCount;
   logic        overflow;
   logic        busy;
   logic        done;

   logic [31:0] oam [64];
   logic [47:0] exp_q [$];
   int total = 0;
   int bad = 0;
   int prevCount = 0;

   sprite_line_eval #(.OAM_NUM(64), .VIEW_NUM(8), .TILE_H(8)) dut (
      .clk(clk), .rstn(rstn), .lineStart(lineStart), .lineY(lineY),
      .oamAddr(oamAddr), .oamData(oamData), .viewWe(viewWe),
      .viewAddr(viewAddr), .viewData(viewData), .viewCount(viewCount),
      .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read OAM
   always @(posedge clk) oamData <= oam[oamAddr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ent(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] t, input logic [7:0] a);
      return {x, y, t, a};
   endfunction

   task automatic clearOam();
      for (int i = 0; i < 64; i++) oam[i] = ent(8'(i), 8'hF0, 8'(i), 8'h00);
   endtask

   task automatic pushWr(input int cyc, input int slot, input logic [31:0] d);
      exp_q.push_back({8'(cyc), 8'(slot), d});
   endtask

   task automatic pushClears(input int hits);
`ifdef SPRITE_EVAL_CLEAR_EN
      for (int j = hits; j < 8; j++) pushWr(67 + j - hits, j, 32'hFFFF_0000);
`endif
   endtask

   function automatic int doneExp(input int hits);
`ifdef SPRITE_EVAL_CLEAR_EN
      return (hits < 8) ? 67 + 8 - hits : 67;
`else
      return 67;
`endif
   endfunction

   task automatic checkResetOutputs();
      check("rst_oamAddr", 64'(oamAddr), 64'd0);
      check("rst_viewWe", 64'(viewWe), 64'd0);
      check("rst_viewAddr", 64'(viewAddr), 64'd0);
      check("rst_viewData", 64'(viewData), 64'd0);
      check("rst_viewCount", 64'(viewCount), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
   endtask

   task automatic logWrite(input int cyc);
      logic [47:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("wr", {8'(cyc), 5'd0, viewAddr, viewData}, 64'(e));
      end else begin
         check("wrExtra", {8'(cyc), 5'd0, viewAddr, viewData}, 64'd0);
      end
   endtask

   // repCyc/rstCyc of 0 mean no re-pulse / no reset
   task automatic runEval(input logic [7:0] y, input int expCount, input logic expOvf,
                          input int repCyc, input int rstCyc);
      int cyc, doneCnt, doneCyc;
      bit fin, rstHit;
      if (rstCyc == 0) pushClears(expCount);
      @(negedge clk);
      lineY = y;
      lineStart = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0; doneCnt = 0; doneCyc = 0; fin = 0; rstHit = 0;
      while (!fin && cyc < 200) begin
         cyc++;
         lineStart = 1'b0;
         if (viewWe) logWrite(cyc);
         if (cyc == 1) begin
            check("c1_busy", 64'(busy), 64'd1);
            check("c1_oamAddr", 64'(oamAddr), 64'd0);
            check("c1_viewCountHeld", 64'(viewCount), 64'(prevCount));
         end
         if (cyc == 11) check("c11_oamAddr", 64'(oamAddr), 64'd10);
         if (done) begin
            doneCnt++;
            doneCyc = cyc;
            check("viewCount", 64'(viewCount), 64'(expCount));
            check("overflow", 64'(overflow), 64'(expOvf));
            check("busyAtDone", 64'(busy), 64'd1);
         end
         if (doneCnt > 0 && cyc == doneCyc + 1) begin
            check("busyFall", 64'(busy), 64'd0);
            fin = 1;
         end else if (cyc == repCyc) begin
            lineY = 8'h99;
            lineStart = 1'b1;
         end else if (cyc == rstCyc) begin
            rstn = 1'b0;
            @(posedge clk);
            #1;
            checkResetOutputs();
            rstn = 1'b1;
            rstHit = 1;
            fin = 1;
         end
         if (!fin) begin
            @(posedge clk);
            #1;
         end
      end
      if (rstHit) begin
         check("wrMissing", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         prevCount = 0;
      end else begin
         check("doneCycle", 64'(doneCyc), 64'(doneExp(expCount)));
         check("doneCount", 64'(doneCnt), 64'd1);
         check("wrMissing", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         prevCount = expCount;
      end
   endtask

   task automatic setupThree();
      clearOam();
      oam[3]  = ent(8'h11, 8'h20, 8'h33, 8'hF5);
      oam[10] = ent(8'h22, 8'h20, 8'h44, 8'h9A);
      oam[40] = ent(8'h33, 8'h20, 8'h55, 8'h6C);
   endtask

   initial begin
      rstn = 1'b0;
      lineStart = 1'b0;
      lineY = 8'h00;
      clearOam();
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs();
      rstn = 1'b1;

      // No hits anywhere
      runEval(8'h10, 0, 1'b0, 0, 0);

      // Three hits, last line of the sprite
      setupThree();
      pushWr(6, 0, oam[3]);
      pushWr(13, 1, oam[10]);
      pushWr(43, 2, oam[40]);
      runEval(8'h27, 3, 1'b0, 0, 0);
      runEval(8'h28, 0, 1'b0, 0, 0);

      // Overflow: 12 hits, only 8 slots
      clearOam();
      for (int i = 0; i < 12; i++) oam[i] = ent(8'(i * 8), 8'h50, 8'(8'h80 + i), 8'h2C);
      for (int i = 0; i < 8; i++) pushWr(3 + i, i, oam[i]);
      runEval(8'h50, 8, 1'b1, 0, 0);

      // Bottom edge of Y range, no wrap
      clearOam();
      oam[5] = ent(8'h77, 8'hFC, 8'h05, 8'h4A);
      pushWr(8, 0, oam[5]);
      runEval(8'hFF, 1, 1'b0, 0, 0);
      runEval(8'h02, 0, 1'b0, 0, 0);

      // lineStart while busy is ignored
      setupThree();
      pushWr(6, 0, oam[3]);
      pushWr(13, 1, oam[10]);
      pushWr(43, 2, oam[40]);
      runEval(8'h27, 3, 1'b0, 20, 0);

      // Reset mid-evaluation, then a full evaluation
      pushWr(6, 0, oam[3]);
      pushWr(13, 1, oam[10]);
      runEval(8'h27, 3, 1'b0, 0, 30);
      pushWr(6, 0, oam[3]);
      pushWr(13, 1, oam[10]);
      pushWr(43, 2, oam[40]);
      runEval(8'h27, 3, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_line_eval.md
# sprite_line_eval

Per-scanline sprite evaluator: the writer side of the sprite view RAM. On each line-start pulse it scans the full sprite attribute table (OAM) for the upcoming game line. It writes up to `VIEW_NUM` Y-hit sprites into the view RAM, and the per-slot tile drawers read them from there. It sits in the PPU between the CPU-written OAM and the view RAM / tile draw array, and is paced by the VGA line timing.

## Interface
Parameters:
- `OAM_NUM`, 64: OAM entries scanned per line. Power of two.
- `VIEW_NUM`, 8: view RAM slots, which is the maximum sprites per line. Power of two.
- `TILE_H`, 8: sprite height in lines.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `lineStart`  in  1: one-cycle pulse requesting evaluation of line `lineY`.
- `lineY`  in  8: game-relative Y of the next line; sampled with `lineStart`.
- `oamAddr`  out  clog2(OAM_NUM): OAM read address, registered.
- `oamData`  in  32: OAM read data, valid one cycle after `oamAddr`.
- `viewWe`  out  1: view RAM write enable, registered.
- `viewAddr`  out  clog2(VIEW_NUM): view RAM slot, registered.
- `viewData`  out  32: view RAM write data, registered.
- `viewCount`  out  clog2(VIEW_NUM)+1: number of valid slots from the last evaluation.
- `overflow`  out  1: the last evaluation found more than `VIEW_NUM` hits.
- `busy`  out  1: evaluation in progress.
- `done`  out  1: one-cycle pulse when an evaluation completes.

Entry format, identical in OAM and view RAM:
- [31:24] posX.
- [23:16] posY.
- [15:8] tileIndex.
- [7] hFlip.
- [6] vFlip.
- [5:4] palette.
- [3:0] reserved, copied unchanged.

## Operation
- States: IDLE, SCAN, DRAIN, CLEAR (CLEAR only when the macro is enabled), DONE.
- IDLE: on `lineStart`, latch `lineY`, zero the hit counter and overflow flag, enter SCAN.
- SCAN: `oamAddr` steps from 0 to OAM_NUM-1, one address per cycle. After issuing OAM_NUM-1, enter DRAIN.
- DRAIN: waits 2 cycles so the last read is compared and written.
- Hit test uses 9-bit unsigned arithmetic with no wrap: `lineY >= posY` and `lineY < posY + TILE_H`.
  - Example: posY=0xFC covers lines 0xFC–0xFF only.
- On a hit with hit counter < VIEW_NUM:
  - write the entry unmodified to slot = hit counter;
  - increment the counter.
- On a hit with counter == VIEW_NUM: set the overflow flag; no write. The scan still runs to the end.
- Priority: lower OAM index gets the lower slot. Slot order equals OAM order.
- DONE: load `viewCount` from the hit counter and `overflow` from the flag, pulse `done`, return to IDLE.
- `lineStart` while `busy` is ignored: no restart, and the latched Y is unchanged.
- `viewCount` and `overflow` hold their values between `done` pulses.

## Timing
- `lineStart` sampled at edge 0:
  - cycle 1: `oamAddr`=0, `busy`=1;
  - cycle k+1: `oamAddr`=k;
  - the write for entry k appears at cycle k+3.
- OAM_NUM=64, macro disabled:
  - last possible write at cycle 66;
  - `done`=1 at cycle 67;
  - `busy` falls at cycle 68;
  - a new `lineStart` is accepted at cycle 68.
- `busy` is high from cycle 1 through the `done` cycle, inclusive.
- Reset values of all outputs: `oamAddr`=0, `viewWe`=0, `viewAddr`=0, `viewData`=0, `viewCount`=0, `overflow`=0, `busy`=0, `done`=0.
- Reset mid-evaluation:
  - aborts on the next edge and returns to IDLE;
  - partial writes already issued stay in the view RAM;
  - `viewCount` reads 0.
- `rstn` low together with `lineStart`: reset wins.

## Configuration
- `SPRITE_EVAL_CLEAR_EN`
  - Defined:
    - after DRAIN, CLEAR writes 32'hFFFF_0000 (posX=posY=0xFF, off-screen) to slots `viewCount`..VIEW_NUM-1, one per cycle;
    - `done` follows the last clear write;
    - with 0 hits: clear writes in cycles 67–74, `done` at 75;
    - with ≥ VIEW_NUM hits: no CLEAR cycles.
  - Undefined: unused slots keep stale contents; consumers must qualify slots with `viewCount`.

## Test plan
- OAM all posY=0xF0, `lineY`=0x10:
  - no `viewWe`;
  - `viewCount`=0, `overflow`=0;
  - `done` at cycle 67 (macro off).
- Entries 3, 10, 40 with posY=0x20; `lineY`=0x27:
  - slot0=entry 3 at cycle 6;
  - slot1=entry 10 at cycle 13;
  - slot2=entry 40 at cycle 43;
  - `viewCount`=3;
  - `lineY`=0x28 instead gives `viewCount`=0.
- 12 entries at posY=0x50 (indices 0–11), `lineY`=0x50:
  - slots 0–7 = entries 0–7;
  - `viewCount`=8, `overflow`=1.
- Entry 5 posY=0xFC:
  - `lineY`=0xFF → hit;
  - `lineY`=0x02 → no hit (no wrap).
- `lineStart` re-pulsed at cycle 20 with `lineY`=0x99:
  - ignored;
  - result matches the original `lineY`;
  - single `done`.
- Reset at cycle 30:
  - outputs return to reset values on the next edge;
  - the next `lineStart` runs a full evaluation.
- Macro on, 2 hits: clear writes of 32'hFFFF_0000 to slots 2–7 in cycles 67–72, `done` at 73.
